// File: rtl/comparn_serial_pkg.sv
// Shared state encoding and width helper for the bit-serial magnitude comparator.
package comparn_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/comparn_bitcell.sv
// One-bit equal / greater / less decision, purely combinational.
module comparn_bitcell (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/comparn_serial.sv
// Bit-serial unsigned comparator: scans MSB to LSB one bit per cycle, stops at the first difference.
// Latency n-k cycles (k = highest differing bit, n when equal); result held in DONE until out_ready.
module comparn_serial
  import comparn_serial_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             A,
  input  logic [n-1:0]             B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     AeqB,
  output logic                     AgtB,
  output logic                     AltB,
  output logic [clog2(n+1)-1:0]    nbits
);

  localparam int IdxW = (n > 1) ? clog2(n) : 1;
  localparam int NbW  = clog2(n + 1);

  state_t            state, stateNxt;
  logic [n-1:0]      aReg, bReg;
  logic [IdxW-1:0]   idx;
  logic              bitEq, bitGt, bitLt;
  logic              lastBit;

  comparn_bitcell uBitcell (
    .a  (aReg[idx]),
    .b  (bReg[idx]),
    .eq (bitEq),
    .gt (bitGt),
    .lt (bitLt)
  );

  assign lastBit   = (idx == '0);
  // Handshake outputs come straight from the state register, so no input reaches them combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: if (in_valid)           stateNxt = RUN;
      RUN:  if (!bitEq || lastBit)  stateNxt = DONE;
      DONE: if (out_ready)          stateNxt = IDLE;
      default:                      stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aReg  <= '0;
      bReg  <= '0;
      idx   <= IdxW'(n - 1);
      nbits <= '0;
      AeqB  <= 1'b0;
      AgtB  <= 1'b0;
      AltB  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg  <= A;
            bReg  <= B;
            idx   <= IdxW'(n - 1);
            nbits <= '0;
            AeqB  <= 1'b0;
            AgtB  <= 1'b0;
            AltB  <= 1'b0;
          end
        end
        RUN: begin
          nbits <= nbits + NbW'(1);
          if (!bitEq) begin
            AeqB <= 1'b0;
            AgtB <= bitGt;
            AltB <= bitLt;
          end else if (lastBit) begin
            AeqB <= 1'b1;
            AgtB <= 1'b0;
            AltB <= 1'b0;
          end else begin
            idx <= idx - IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparn_serial.sv
// Bench for comparn_serial at n=4 and n=8 against a plain-arithmetic compare model.
module tb_comparn_serial;

  logic clk = 1'b0;
  logic rst_n;

  logic       iv4, ir4, ov4, or4, eq4, gt4, lt4;
  logic [3:0] a4, b4;
  logic [2:0] nb4;

  logic       iv8, ir8, ov8, or8, eq8, gt8, lt8;
  logic [7:0] a8, b8;
  logic [3:0] nb8;

  int nAsserts = 0;
  int nFail    = 0;

  logic [31:0] obsV, obsIR, obsEq, obsGt, obsLt, obsNb;

  always #5 clk = ~clk;

  comparn_serial #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .out_valid(ov4), .out_ready(or4), .AeqB(eq4), .AgtB(gt4), .AltB(lt4), .nbits(nb4)
  );

  comparn_serial #(.n(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .AeqB(eq8), .AgtB(gt8), .AltB(lt8), .nbits(nb8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    nAsserts++;
    assert (obs === 32'(exp)) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int w);
    if (w == 4) begin
      obsV = 32'(ov4); obsIR = 32'(ir4); obsEq = 32'(eq4);
      obsGt = 32'(gt4); obsLt = 32'(lt4); obsNb = 32'(nb4);
    end else begin
      obsV = 32'(ov8); obsIR = 32'(ir8); obsEq = 32'(eq8);
      obsGt = 32'(gt8); obsLt = 32'(lt8); obsNb = 32'(nb8);
    end
  endtask

  task automatic setIn(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      iv4 = v; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      iv8 = v; a8 = a; b8 = b;
    end
  endtask

  task automatic setOr(input int w, input logic v);
    if (w == 4) or4 = v;
    else        or8 = v;
  endtask

  // Full transaction: offer, wait for result with a bound, check against the model,
  // optionally stall the consumer for `hold` cycles, then retire.
  task automatic runTxn(input int w, input logic [7:0] aIn, input logic [7:0] bIn, input int hold);
    logic [7:0] a, b, diff;
    int expNb, cnt, expEq, expGt, expLt;
    logic [31:0] heldNb, heldEq, heldGt, heldLt;
    a = (w == 4) ? {4'h0, aIn[3:0]} : aIn;
    b = (w == 4) ? {4'h0, bIn[3:0]} : bIn;
    expEq = (a == b) ? 1 : 0;
    expGt = (a > b) ? 1 : 0;
    expLt = (a < b) ? 1 : 0;
    diff  = a ^ b;
    expNb = w;
    for (int i = 0; i < w; i++) if (diff[i]) expNb = w - i;

    @(negedge clk);
    sample(w);
    check("in_ready idle", obsIR, 1);
    check("out_valid idle", obsV, 0);
    setIn(w, 1'b1, a, b);
    @(negedge clk);
    setIn(w, 1'b0, ~a, ~b);
    sample(w);
    check("in_ready busy", obsIR, 0);
    cnt = 0;
    while (obsV !== 32'd1 && cnt < 3 * w + 4) begin
      @(negedge clk);
      cnt++;
      sample(w);
    end
    check("out_valid rises", obsV, 1);
    check("run cycles", 32'(cnt), expNb);
    check("nbits", obsNb, expNb);
    check("AeqB", obsEq, expEq);
    check("AgtB", obsGt, expGt);
    check("AltB", obsLt, expLt);
    check("one-hot", obsEq + obsGt + obsLt, 1);
    check("in_ready done", obsIR, 0);
    heldNb = obsNb; heldEq = obsEq; heldGt = obsGt; heldLt = obsLt;

    for (int h = 0; h < hold; h++) begin
      setIn(w, 1'b1, 8'($urandom), 8'($urandom));
      @(negedge clk);
      sample(w);
      check("hold out_valid", obsV, 1);
      check("hold in_ready", obsIR, 0);
      check("hold nbits", obsNb, int'(heldNb));
      check("hold flags", {obsEq[0], obsGt[0], obsLt[0]}, int'({heldEq[0], heldGt[0], heldLt[0]}));
    end
    setIn(w, 1'b0, 8'($urandom), 8'($urandom));

    setOr(w, 1'b1);
    @(negedge clk);
    setOr(w, 1'b0);
    sample(w);
    check("retire out_valid", obsV, 0);
    check("retire in_ready", obsIR, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    setIn(4, 1'b0, 8'h00, 8'h00);
    setIn(8, 1'b0, 8'h00, 8'h00);
    or4 = 1'b0;
    or8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int w = 4; w <= 8; w += 4) begin
      sample(w);
      check("reset out_valid", obsV, 0);
      check("reset in_ready", obsIR, 1);
      check("reset flags", {obsEq[0], obsGt[0], obsLt[0]}, 0);
      check("reset nbits", obsNb, 0);
    end
    rst_n = 1'b1;

    runTxn(4, 8'b1010, 8'b0110, 0);
    runTxn(4, 8'b0101, 8'b0101, 0);
    runTxn(4, 8'b0010, 8'b0011, 0);
    runTxn(4, 8'b0101, 8'b0101, 5);
    runTxn(8, 8'hFF, 8'h00, 0);
    runTxn(8, 8'h00, 8'h01, 3);

    // Abort mid-scan of an equal pair: no result may appear afterwards.
    @(negedge clk);
    setIn(4, 1'b1, 8'h00, 8'h00);
    @(negedge clk);
    setIn(4, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sample(4);
    check("abort out_valid", obsV, 0);
    check("abort in_ready", obsIR, 1);
    check("abort nbits", obsNb, 0);
    check("abort flags", {obsEq[0], obsGt[0], obsLt[0]}, 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      sample(4);
      check("no result after abort", obsV, 0);
    end

    for (int t = 0; t < 1000; t++) runTxn(4, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    for (int t = 0; t < 1000; t++) runTxn(8, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/comparn_serial.md
COMPARN_SERIAL -- requirements
Module: comparn_serial

Interface
REQ-001 SHALL have parameter n, default 4, meaning operand width in bits (n >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands A and B are offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port A  input  n  operand A, unsigned, sampled on acceptance.
REQ-007 SHALL have port B  input  n  operand B, unsigned, sampled on acceptance.
REQ-008 SHALL have port out_valid  output  1  result fields are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port AeqB  output  1  A == B.
REQ-011 SHALL have port AgtB  output  1  A > B.
REQ-012 SHALL have port AltB  output  1  A < B.
REQ-013 SHALL have port nbits  output  clog2(n+1)  number of bit positions examined, MSB first.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; acceptance SHALL occur on an edge where in_valid && in_ready.
REQ-016 On acceptance, SHALL latch A and B, set the bit index to n-1, clear the counter, and go to RUN.
REQ-017 In RUN, SHALL examine one bit per cycle at the index, MSB to LSB, and increment nbits.
REQ-018 If A[idx] != B[idx], SHALL set AgtB = A[idx] & ~B[idx], AltB = ~A[idx] & B[idx], AeqB = 0, then go to DONE (early termination).
REQ-019 If the bits are equal and idx == 0, SHALL set AeqB = 1, AgtB = 0, AltB = 0, then go to DONE.
REQ-020 If the bits are equal and idx > 0, SHALL decrement idx and remain in RUN.
REQ-021 Latency: the number of RUN cycles SHALL be n-k, where k is the highest differing bit index, or n when A == B; out_valid rises on the edge that ends the last RUN cycle.
REQ-022 SHALL hold out_valid, AeqB, AgtB, AltB and nbits stable in DONE until out_ready = 1.
REQ-023 SHALL return from DONE to IDLE on the edge where out_valid && out_ready; out_valid SHALL be 0 in IDLE and RUN.
REQ-024 Exactly one of AeqB, AgtB and AltB SHALL be 1 whenever out_valid = 1.
REQ-025 SHALL ignore changes on A and B after acceptance.
REQ-026 SHALL ignore in_valid outside IDLE; no back-to-back acceptance in the same cycle as result retirement (min one IDLE cycle).
REQ-027 The index SHALL never decrement below 0; there is no wrap-around.

Reset
REQ-028 When rst_n = 0 at a rising edge, SHALL set the state to IDLE, in_ready = 1, out_valid = 0, AeqB = 0, AgtB = 0, AltB = 0, nbits = 0, idx = n-1, and clear the operand registers.
REQ-029 Reset SHALL take priority over any handshake and SHALL abort RUN or DONE with no result delivered.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the index-width helper clog2.
REQ-031 SHALL contain one sub-module, comparn_bitcell: combinational one-bit eq/gt/lt from A[idx] and B[idx], reused by the FSM.
REQ-032 SHALL use no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Verification
REQ-033 n=4, A=4'b1010, B=4'b0110, out_ready=1 -> after 1 RUN cycle: AgtB=1, AeqB=0, AltB=0, nbits=1.
REQ-034 n=4, A=4'b0101, B=4'b0101 -> after 4 RUN cycles: AeqB=1, nbits=4.
REQ-035 n=4, A=4'b0010, B=4'b0011 -> after 4 RUN cycles: AltB=1, nbits=4.
REQ-036 Hold out_ready=0 for 5 cycles after done -> out_valid and result stable; in_ready=0; in_valid pulses ignored.
REQ-037 Assert rst_n=0 mid-RUN (A=4'b0000, B=4'b0000, cycle 2) -> next cycle IDLE, out_valid=0, in_ready=1, no result.
REQ-038 Random A, B over 1000 transactions (n=4 and n=8) -> result matches a reference compare; the one-hot assertion always holds; nbits = n-k.
